// File: rtl/weight_load_sequencer_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package : weight_load_sequencer_pkg                              |
// | Brief   : FSM state encoding and row-index width helper shared   |
// |           by the weight-load sequencer and its read pipe.        |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
package weight_load_sequencer_pkg;

  // Encoding is visible on the debug state output, so values are fixed.
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PS_ACCESS = 3'd1,
    S_ISSUE     = 3'd2,
    S_DRAIN     = 3'd3,
    S_DONE      = 3'd4
  } wls_state_e;

  // Row index width: $clog2(rows), but never narrower than one bit.
  function automatic int wls_row_width(input int rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/weight_load_sequencer_rd_pipe.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : weight_load_sequencer_rd_pipe                           |
// | Brief  : DEPTH-stage {valid,row} shift register that follows     |
// |          each weight-memory read until its data returns.         |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module weight_load_sequencer_rd_pipe #(
  parameter int DEPTH = 1,
  parameter int RW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_flush,
  input  logic          i_valid,
  input  logic [RW-1:0] i_row,
  output logic          o_valid,
  output logic [RW-1:0] o_row,
  output logic          o_inner_busy
);

  logic [DEPTH-1:0]         r_valid;
  logic [DEPTH-1:0][RW-1:0] r_row;
  logic                     w_inner_busy;

  // Shift reads toward the output; a flush also drops the read entering this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_row   <= '0;
    end else if (i_flush) begin
      r_valid <= '0;
      r_row   <= '0;
    end else begin
      r_valid[0] <= i_valid;
      r_row[0]   <= i_row;
      for (int i = 1; i < DEPTH; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_row[i]   <= r_row[i-1];
      end
    end
  end

  // Any read still short of the output stage means the pipe is not empty next cycle.
  always_comb begin
    w_inner_busy = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      w_inner_busy = w_inner_busy | r_valid[i];
    end
  end

  assign o_valid      = r_valid[DEPTH-1];
  assign o_row        = r_row[DEPTH-1];
  assign o_inner_busy = w_inner_busy;

endmodule
`default_nettype wire

// File: rtl/weight_load_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : weight_load_sequencer                                   |
// | Brief  : Owns the weight-memory port: streams ROWS words into    |
// |          the MXU weight registers and arbitrates PS-side access. |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module weight_load_sequencer
  import weight_load_sequencer_pkg::*;
#(
  parameter int ROWS                 = 3,
  parameter int DATA_WIDTH_WMEMORY   = 64,
  parameter int ADDRESS_SIZE_WMEMORY = 32,
  parameter int RD_LATENCY           = 1,
  parameter int RW                   = wls_row_width(ROWS)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_ld_start,
  input  logic [ADDRESS_SIZE_WMEMORY-1:0] i_ld_base_addr,
  input  logic                            i_ld_abort,
  output logic                            o_ld_busy,
  output logic                            o_ld_done,
  input  logic                            i_ps_wm_req,
  input  logic                            i_ps_wm_we,
  input  logic [ADDRESS_SIZE_WMEMORY-1:0] i_ps_wm_address,
  output logic                            o_ps_wm_gnt,
  output logic                            o_wm_ce,
  output logic                            o_wm_we,
  output logic [ADDRESS_SIZE_WMEMORY-1:0] o_wm_address,
  input  logic [DATA_WIDTH_WMEMORY-1:0]   i_wm_dout,
  output logic [DATA_WIDTH_WMEMORY-1:0]   o_mxu_w_data,
  output logic [RW-1:0]                   o_mxu_w_row,
  output logic                            o_mxu_w_valid,
  output logic [2:0]                      o_state_out
);

  localparam int AW = ADDRESS_SIZE_WMEMORY;

  wls_state_e       r_state;
  logic [AW-1:0]    r_base;
  logic [RW-1:0]    r_issue_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_gnt;
  logic             r_ce;
  logic             r_we;
  logic [AW-1:0]    r_addr;

  logic             w_loading;
  logic             w_abort;
  logic             w_last;
  logic [RW-1:0]    w_cnt_nxt;
  logic             w_pipe_in_valid;
  logic [RW-1:0]    w_pipe_in_row;
  logic             w_pipe_valid;
  logic [RW-1:0]    w_pipe_row;
  logic             w_pipe_inner_busy;

  assign w_loading       = (r_state == S_ISSUE) || (r_state == S_DRAIN);
  assign w_abort         = i_ld_abort && w_loading;
  assign w_last          = (r_issue_cnt == RW'(ROWS - 1));
  assign w_cnt_nxt       = r_issue_cnt + 1'b1;
  // A read is on the port whenever the enable is up and the PS does not own it.
  assign w_pipe_in_valid = r_ce && !r_gnt;
  assign w_pipe_in_row   = w_pipe_in_valid ? r_issue_cnt : '0;

  weight_load_sequencer_rd_pipe #(
    .DEPTH (RD_LATENCY),
    .RW    (RW)
  ) u_rd_pipe (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_flush      (w_abort),
    .i_valid      (w_pipe_in_valid),
    .i_row        (w_pipe_in_row),
    .o_valid      (w_pipe_valid),
    .o_row        (w_pipe_row),
    .o_inner_busy (w_pipe_inner_busy)
  );

  // Control FSM: sequences the load, arbitrates the port and registers all port outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_base      <= '0;
      r_issue_cnt <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_gnt       <= 1'b0;
      r_ce        <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Loader has priority over a PS request arriving in the same cycle.
          if (i_ld_start) begin
            r_state     <= S_ISSUE;
            r_base      <= i_ld_base_addr;
            r_issue_cnt <= '0;
            r_busy      <= 1'b1;
            r_ce        <= 1'b1;
            r_we        <= 1'b0;
            r_addr      <= i_ld_base_addr;
          end else if (i_ps_wm_req) begin
            r_state <= S_PS_ACCESS;
            r_gnt   <= 1'b1;
            r_ce    <= 1'b1;
            r_we    <= i_ps_wm_we;
            r_addr  <= i_ps_wm_address;
          end
        end
        S_PS_ACCESS: begin
          if (i_ps_wm_req) begin
            r_ce   <= 1'b1;
            r_we   <= i_ps_wm_we;
            r_addr <= i_ps_wm_address;
          end else begin
            r_state <= S_IDLE;
            r_gnt   <= 1'b0;
            r_ce    <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
          end
        end
        S_ISSUE: begin
          if (w_abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_ce    <= 1'b0;
            r_addr  <= '0;
          end else if (w_last) begin
            r_state <= S_DRAIN;
            r_ce    <= 1'b0;
            r_addr  <= '0;
          end else begin
            r_issue_cnt <= w_cnt_nxt;
            r_ce        <= 1'b1;
            r_we        <= 1'b0;
            r_addr      <= r_base + AW'(w_cnt_nxt);
          end
        end
        S_DRAIN: begin
          // Leave once only the output stage may still hold a read.
          if (w_abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (!w_pipe_inner_busy) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state     <= S_IDLE;
          r_issue_cnt <= '0;
          r_busy      <= 1'b0;
          r_gnt       <= 1'b0;
          r_ce        <= 1'b0;
          r_we        <= 1'b0;
          r_addr      <= '0;
        end
      endcase
    end
  end

  assign o_ld_busy     = r_busy;
  assign o_ld_done     = r_done;
  assign o_ps_wm_gnt   = r_gnt;
  assign o_wm_ce       = r_ce;
  assign o_wm_we       = r_we;
  assign o_wm_address  = r_addr;
  assign o_state_out   = r_state;
  assign o_mxu_w_valid = w_pipe_valid;
  assign o_mxu_w_row   = w_pipe_row;
  // Memory read data is already registered at its source; it is forwarded in the
  // cycle it arrives so row 0 lands RD_LATENCY cycles after its read, and held at
  // zero whenever no tracked read is returning.
  assign o_mxu_w_data  = w_pipe_valid ? i_wm_dout : '0;

endmodule
`default_nettype wire

// File: tb/tb_weight_load_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : tb_weight_load_sequencer                                |
// | Brief  : Directed vector table plus hand-written sequences for   |
// |          the weight-load sequencer (RD_LATENCY 1 and 3).         |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_weight_load_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, rst3_n;
  logic        st, ab, ps, pwe, st3;
  logic [31:0] base, paddr, base3;
  logic        busy, done, gnt, ce, we, valid;
  logic        busy3, done3, gnt3, ce3, we3, valid3;
  logic [31:0] addr, addr3;
  logic [63:0] dout, data, dout3, data3;
  logic [1:0]  row, row3;
  logic [2:0]  state, state3;

  int checks = 0;
  int errors = 0;

  weight_load_sequencer #(.ROWS(3), .DATA_WIDTH_WMEMORY(64), .ADDRESS_SIZE_WMEMORY(32), .RD_LATENCY(1)) dut (
    .clk(clk), .rst_n(rst_n), .i_ld_start(st), .i_ld_base_addr(base), .i_ld_abort(ab),
    .o_ld_busy(busy), .o_ld_done(done), .i_ps_wm_req(ps), .i_ps_wm_we(pwe),
    .i_ps_wm_address(paddr), .o_ps_wm_gnt(gnt), .o_wm_ce(ce), .o_wm_we(we),
    .o_wm_address(addr), .i_wm_dout(dout), .o_mxu_w_data(data), .o_mxu_w_row(row),
    .o_mxu_w_valid(valid), .o_state_out(state));

  weight_load_sequencer #(.ROWS(3), .DATA_WIDTH_WMEMORY(64), .ADDRESS_SIZE_WMEMORY(32), .RD_LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst3_n), .i_ld_start(st3), .i_ld_base_addr(base3), .i_ld_abort(1'b0),
    .o_ld_busy(busy3), .o_ld_done(done3), .i_ps_wm_req(1'b0), .i_ps_wm_we(1'b0),
    .i_ps_wm_address(32'h0), .o_ps_wm_gnt(gnt3), .o_wm_ce(ce3), .o_wm_we(we3),
    .o_wm_address(addr3), .i_wm_dout(dout3), .o_mxu_w_data(data3), .o_mxu_w_row(row3),
    .o_mxu_w_valid(valid3), .o_state_out(state3));

  // Weight memory contents: word at address a is {~a, a}.
  function automatic logic [63:0] word(input logic [31:0] a);
    return {~a, a};
  endfunction

  initial dout = 64'h0;
  always @(posedge clk) if (ce && !we) dout <= word(addr);

  logic [63:0] m3 [3];
  initial begin m3[0] = 64'h0; m3[1] = 64'h0; m3[2] = 64'h0; end
  always @(posedge clk) begin
    m3[0] <= (ce3 && !we3) ? word(addr3) : 64'h0;
    m3[1] <= m3[0];
    m3[2] <= m3[1];
  end
  assign dout3 = m3[2];

  typedef struct {
    logic st; logic [31:0] base; logic ps; logic pwe; logic [31:0] paddr; logic ab;
    logic [2:0] e_state; logic e_busy; logic e_done; logic e_gnt; logic e_ce; logic e_we;
    logic [31:0] e_addr; logic e_valid; logic [1:0] e_row; logic [63:0] e_data;
  } vec_t;
  vec_t vq[$];

  task automatic add(input logic st_i, input logic [31:0] base_i, input logic ps_i, input logic pwe_i,
                     input logic [31:0] paddr_i, input logic ab_i, input logic [2:0] es, input logic eb,
                     input logic ed, input logic eg, input logic ec, input logic ew, input logic [31:0] ea,
                     input logic ev, input logic [1:0] er, input logic [63:0] edat);
    vec_t v;
    v.st = st_i; v.base = base_i; v.ps = ps_i; v.pwe = pwe_i; v.paddr = paddr_i; v.ab = ab_i;
    v.e_state = es; v.e_busy = eb; v.e_done = ed; v.e_gnt = eg; v.e_ce = ec; v.e_we = ew;
    v.e_addr = ea; v.e_valid = ev; v.e_row = er; v.e_data = edat;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 0; rst3_n = 0;
    st = 0; ab = 0; ps = 0; pwe = 0; base = 0; paddr = 0; st3 = 0; base3 = 0;

    // Basic load from 0x10; a second start while busy is ignored
    add(1, 32'h10, 0, 0, 0, 0, 2, 1, 0, 0, 1, 0, 32'h10, 0, 0, 64'h0);
    add(0, 32'h0,  0, 0, 0, 0, 2, 1, 0, 0, 1, 0, 32'h11, 1, 0, 64'hFFFFFFEF_00000010);
    add(1, 32'h99, 0, 0, 0, 0, 2, 1, 0, 0, 1, 0, 32'h12, 1, 1, 64'hFFFFFFEE_00000011);
    add(0, 32'h0,  0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 32'h0,  1, 2, 64'hFFFFFFED_00000012);
    add(0, 32'h0,  0, 0, 0, 0, 4, 1, 1, 0, 0, 0, 32'h0,  0, 0, 64'h0);
    add(0, 32'h0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,  0, 0, 64'h0);
    // Address wrap
    add(1, 32'hFFFFFFFF, 0, 0, 0, 0, 2, 1, 0, 0, 1, 0, 32'hFFFFFFFF, 0, 0, 64'h0);
    add(0, 32'h0, 0, 0, 0, 0, 2, 1, 0, 0, 1, 0, 32'h0, 1, 0, 64'h00000000_FFFFFFFF);
    add(0, 32'h0, 0, 0, 0, 0, 2, 1, 0, 0, 1, 0, 32'h1, 1, 1, 64'hFFFFFFFF_00000000);
    add(0, 32'h0, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 32'h0, 1, 2, 64'hFFFFFFFE_00000001);
    add(0, 32'h0, 0, 0, 0, 0, 4, 1, 1, 0, 0, 0, 32'h0, 0, 0, 64'h0);
    add(0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 64'h0);
    // Simultaneous start and PS request: load first, then PS write to 0x5
    add(1, 32'h20, 1, 1, 32'h5, 0, 2, 1, 0, 0, 1, 0, 32'h20, 0, 0, 64'h0);
    add(0, 32'h0,  1, 1, 32'h5, 0, 2, 1, 0, 0, 1, 0, 32'h21, 1, 0, 64'hFFFFFFDF_00000020);
    add(0, 32'h0,  1, 1, 32'h5, 0, 2, 1, 0, 0, 1, 0, 32'h22, 1, 1, 64'hFFFFFFDE_00000021);
    add(0, 32'h0,  1, 1, 32'h5, 0, 3, 1, 0, 0, 0, 0, 32'h0,  1, 2, 64'hFFFFFFDD_00000022);
    add(0, 32'h0,  1, 1, 32'h5, 0, 4, 1, 1, 0, 0, 0, 32'h0,  0, 0, 64'h0);
    add(0, 32'h0,  1, 1, 32'h5, 0, 0, 0, 0, 0, 0, 0, 32'h0,  0, 0, 64'h0);
    add(0, 32'h0,  1, 1, 32'h5, 0, 1, 0, 0, 1, 1, 1, 32'h5,  0, 0, 64'h0);
    add(0, 32'h0,  0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 32'h0,  0, 0, 64'h0);
    // PS holds the port for 4 cycles; start pulsed mid-way is ignored
    add(0, 32'h0,  1, 0, 32'h40, 0, 1, 0, 0, 1, 1, 0, 32'h40, 0, 0, 64'h0);
    add(1, 32'h80, 1, 0, 32'h41, 0, 1, 0, 0, 1, 1, 0, 32'h41, 0, 0, 64'h0);
    add(0, 32'h0,  1, 0, 32'h42, 0, 1, 0, 0, 1, 1, 0, 32'h42, 0, 0, 64'h0);
    add(0, 32'h0,  1, 0, 32'h43, 0, 1, 0, 0, 1, 1, 0, 32'h43, 0, 0, 64'h0);
    add(0, 32'h0,  0, 0, 32'h0,  0, 0, 0, 0, 0, 0, 0, 32'h0,  0, 0, 64'h0);
    add(0, 32'h0,  0, 0, 32'h0,  0, 0, 0, 0, 0, 0, 0, 32'h0,  0, 0, 64'h0);
    // Abort while row 1 is issued; abort in IDLE does nothing
    add(0, 32'h0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,  0, 0, 64'h0);
    add(1, 32'h30, 0, 0, 0, 0, 2, 1, 0, 0, 1, 0, 32'h30, 0, 0, 64'h0);
    add(0, 32'h0,  0, 0, 0, 0, 2, 1, 0, 0, 1, 0, 32'h31, 1, 0, 64'hFFFFFFCF_00000030);
    add(0, 32'h0,  0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 32'h0,  0, 0, 64'h0);
    add(0, 32'h0,  0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 32'h0,  0, 0, 64'h0);
    add(0, 32'h0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,  0, 0, 64'h0);

    // Reset state of both instances
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", {61'h0, state}, 64'h0);
    chk("rst_busy_done_gnt", {61'h0, busy, done, gnt}, 64'h0);
    chk("rst_wm", {30'h0, ce, we, addr}, 64'h0);
    chk("rst_mxu", {61'h0, valid, row}, 64'h0);
    chk("rst_data", data, 64'h0);
    chk("rst3_state", {61'h0, state3}, 64'h0);
    @(negedge clk);
    rst_n = 1; rst3_n = 1;

    foreach (vq[i]) begin
      @(negedge clk);
      st = vq[i].st; base = vq[i].base; ps = vq[i].ps; pwe = vq[i].pwe;
      paddr = vq[i].paddr; ab = vq[i].ab;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_state", i), {61'h0, state}, {61'h0, vq[i].e_state});
      chk($sformatf("v%0d_busy", i), {63'h0, busy}, {63'h0, vq[i].e_busy});
      chk($sformatf("v%0d_done", i), {63'h0, done}, {63'h0, vq[i].e_done});
      chk($sformatf("v%0d_gnt", i), {63'h0, gnt}, {63'h0, vq[i].e_gnt});
      chk($sformatf("v%0d_ce_we", i), {62'h0, ce, we}, {62'h0, vq[i].e_ce, vq[i].e_we});
      chk($sformatf("v%0d_addr", i), {32'h0, addr}, {32'h0, vq[i].e_addr});
      chk($sformatf("v%0d_valid_row", i), {61'h0, valid, row}, {61'h0, vq[i].e_valid, vq[i].e_row});
      chk($sformatf("v%0d_data", i), data, vq[i].e_data);
    end

    // RD_LATENCY=3: async reset in the middle of DRAIN
    @(negedge clk);
    st3 = 1; base3 = 32'h50;
    @(negedge clk);
    st3 = 0;
    begin
      int n;
      n = 0;
      while (state3 !== 3'd3 && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    chk("lat3_in_drain", {61'h0, state3}, 64'd3);
    chk("lat3_row0_valid_before_rst", {61'h0, valid3, row3}, {61'h0, 1'b1, 2'd0});
    chk("lat3_row0_data_before_rst", data3, word(32'h50));
    #1 rst3_n = 0;
    #1;
    chk("arst_state", {61'h0, state3}, 64'h0);
    chk("arst_busy_done_gnt", {61'h0, busy3, done3, gnt3}, 64'h0);
    chk("arst_wm", {30'h0, ce3, we3, addr3}, 64'h0);
    chk("arst_mxu", {61'h0, valid3, row3}, 64'h0);
    chk("arst_data", data3, 64'h0);
    @(negedge clk);
    rst3_n = 1;
    @(negedge clk);
    st3 = 1; base3 = 32'h60;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) st3 = 0;
      chk($sformatf("lat3_c%0d_valid", k), {63'h0, valid3}, {63'h0, (k >= 4 && k <= 6)});
      if (k >= 4 && k <= 6) begin
        chk($sformatf("lat3_c%0d_row", k), {62'h0, row3}, 64'(k - 4));
        chk($sformatf("lat3_c%0d_data", k), data3, word(32'h60 + 32'(k - 4)));
      end
      if (k <= 3) chk($sformatf("lat3_c%0d_addr", k), {31'h0, ce3, addr3}, {31'h0, 1'b1, 32'h60 + 32'(k - 1)});
      chk($sformatf("lat3_c%0d_done", k), {63'h0, done3}, {63'h0, (k == 7)});
      chk($sformatf("lat3_c%0d_busy", k), {63'h0, busy3}, {63'h0, (k <= 7)});
    end
    chk("lat3_final_state", {61'h0, state3}, 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
